// File: rtl/uart_transmitter_pkg.sv
// Frame constants and FSM state type shared by the UART transmitter and receiver.
package uart_transmitter_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;
   // Bit index wide enough to walk the data bits (also reused for stop bits).
   localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

   // Clocks per bit, integer-truncated.
   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Write-side port bundle of the UART transmitter: push request/data and FIFO status.
interface uart_transmitter_if #(
   parameter int FIFO_DEPTH = 16
) ();

   logic                                wr_en;
   logic [7:0]                          wr_data;
   logic                                full;
   logic [$clog2(FIFO_DEPTH+1)-1:0]     count;

   // Producer side (CPU store path).
   modport master (
      output wr_en,
      output wr_data,
      input  full,
      input  count
   );

   // Transmitter side.
   modport slave (
      input  wr_en,
      input  wr_data,
      output full,
      output count
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy count and wrap-around pointers.
// The head entry is read asynchronously so the FSM can load it on the pop edge.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wr_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rd_data,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the registered count, so a write in a full cycle is
   // dropped even if the FSM pops in that same cycle.
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;

   // Storage write; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointer and occupancy update; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// 8-N-1 UART transmitter: FIFO-buffered bytes shifted out LSB first at CLK_FREQ/BAUD.
module uart_transmitter
   import uart_transmitter_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   uart_transmitter_if.slave  wr_if,
   output logic               busy,
   output logic               tx_done,
   output logic               tx
);

   localparam int DIV   = baud_div(CLK_FREQ, BAUD);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [UART_IDX_W-1:0] LAST_DATA = UART_IDX_W'(UART_DATA_BITS - 1);
   localparam logic [UART_IDX_W-1:0] LAST_STOP = UART_IDX_W'(UART_STOP_BITS - 1);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_transmitter: CLK_FREQ/BAUD must be at least 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
         $error("uart_transmitter: FIFO_DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   uart_tx_state_t                state_reg;
   uart_tx_state_t                state_next;
   logic [CNT_W-1:0]              baud_cnt_reg;
   logic [CNT_W-1:0]              baud_cnt_next;
   logic [UART_IDX_W-1:0]         bit_idx_reg;
   logic [UART_IDX_W-1:0]         bit_idx_next;
   logic [UART_DATA_BITS-1:0]     shreg_reg;
   logic [UART_DATA_BITS-1:0]     shreg_next;
   logic                          tx_reg;
   logic                          tx_next;
   logic                          pop;
   logic                          bit_end;
   logic                          fifo_empty;
   logic [UART_DATA_BITS-1:0]     fifo_rd_data;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (wr_if.wr_en),
      .wr_data (wr_if.wr_data),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (wr_if.full),
      .empty   (fifo_empty),
      .count   (wr_if.count)
   );

   assign bit_end = (baud_cnt_reg == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; leaving STOP with data queued goes straight to START.
   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = START;
               pop        = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end && bit_idx_reg == LAST_DATA) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end && bit_idx_reg == LAST_STOP) begin
               if (!fifo_empty) begin
                  state_next = START;
                  pop        = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath next values and outputs; tx is computed from the next state so it can be registered.
   always_comb begin
      baud_cnt_next = baud_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      shreg_next    = shreg_reg;
      tx_next       = 1'b1;
      if (pop) begin
         shreg_next    = fifo_rd_data;
         baud_cnt_next = '0;
         bit_idx_next  = '0;
      end else if (state_reg == IDLE) begin
         baud_cnt_next = '0;
      end else if (bit_end) begin
         baud_cnt_next = '0;
         bit_idx_next  = (state_next != state_reg) ? '0 : bit_idx_reg + 1'b1;
      end else begin
         baud_cnt_next = baud_cnt_reg + 1'b1;
      end
      case (state_next)
         IDLE:    tx_next = 1'b1;
         START:   tx_next = 1'b0;
         DATA:    tx_next = shreg_next[bit_idx_next];
         STOP:    tx_next = 1'b1;
         default: tx_next = 1'b1;
      endcase
      tx_done = (state_reg == STOP) && bit_end && (bit_idx_reg == LAST_STOP);
      busy    = (state_reg != IDLE) || !fifo_empty;
   end

   // Datapath registers; reset aborts any frame and parks the line high.
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shreg_reg    <= '0;
         tx_reg       <= 1'b1;
      end else begin
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shreg_reg    <= shreg_next;
         tx_reg       <= tx_next;
      end
   end

   assign tx = tx_reg;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Byte-serial UART transmitter, the outbound counterpart of the existing UART receiver: the CPU's MMIO store path pushes bytes into a small FIFO and the block shifts them out on `tx` as 8-N-1 frames at a fixed baud rate. It sits beside the receiver under the top level and is clocked from the board clock. It provides a console/debug output channel and allows board-to-host echo of uploaded data.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `DIV = CLK_FREQ / BAUD`, integer-truncated (868 at the defaults). Elaboration error if `DIV < 2`.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of 2 and ≥ 2, else elaboration error.

Ports:
- `clk`  in  1: single clock. One clock; all logic sits on its rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `wr_en`  in  1: push request.
- `wr_data`  in  8: byte to push.
- `full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `count`  out  `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.
- `busy`  out  1: set when the FSM is not IDLE or the FIFO is non-empty.
- `tx_done`  out  1: one-cycle pulse at the end of each stop bit.
- `tx`  out  1: serial line. Idle level is high.

## Operation
- **Push:** a write is accepted on an edge where `wr_en && !full`. `full` is evaluated from the registered count, so a write in a full cycle is dropped even if a pop happens in the same cycle. A dropped write leaves the FIFO and `count` unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START: `tx=0` for DIV clocks, then go to DATA with bit index 0.
  - DATA: `tx = shreg[idx]`, LSB first, DIV clocks per bit. After bit 7, go to STOP.
  - STOP: `tx=1` for DIV clocks. On the last STOP cycle, pulse `tx_done`.
- **Leaving STOP:** if the FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames. Otherwise go to IDLE.
- **Baud counter:** counts 0..DIV-1 and wraps. A bit boundary occurs when the counter equals DIV-1.
- **Simultaneous push and pop:** when not full, the count is unchanged and the data ordering is preserved.
- **Push into an empty FIFO while IDLE:** the entry is popped on the very next edge.
- **Reset values:**
  - Outputs: `tx=1`, `busy=0`, `full=0`, `count=0`, `tx_done=0`.
  - Internal: FIFO pointers 0, FSM in IDLE, baud counter 0.
- **Reset mid-frame:** the frame is aborted and `tx` returns high on the reset edge. Queued bytes are discarded.

## Timing
- `tx` is registered; there is no combinational path from `wr_en` to `tx`.
- Write accepted at edge E0 with the FSM idle and the FIFO empty:
  - pop and `tx=0` at edge E1, so the start bit begins 1 clock after acceptance.
- Frame length is exactly 10·DIV clocks.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- `tx_done` is high during the final STOP cycle only.
- `count` and `full` update on the edge of push/pop.
- `busy` falls in the cycle after the final `tx_done`, provided the FIFO is empty.

## Structure
- Shared package holds the frame constants: `UART_DATA_BITS=8`, `UART_STOP_BITS=1`, and the `uart_tx_state_t` enum (IDLE/START/DATA/STOP). The receiver side reuses them.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with registered count, wrap-around pointers of `$clog2(FIFO_DEPTH)` bits, and push/pop/full/empty. The FSM, baud counter and shift register live in the top module.
- Expected size is about 200 lines of RTL in total.

## Test plan
All cases use `CLK_FREQ=16`, `BAUD=1` (DIV=16) unless stated.
1. **Single byte:** push 0x55 at E0 → `tx` low E1–E16; data bits 1,0,1,0,1,0,1,0 at 16 clocks each; high stop bit; `tx_done` pulse at clock 160 after E1; `busy` then falls.
2. **Back-to-back:** push 0xA5 and 0x3C on consecutive cycles → two frames with no idle cycle between them; `count` goes 1,1→0 as the pops occur; the decoded bytes match.
3. **Overflow:** with `FIFO_DEPTH=4`, push 6 bytes on consecutive cycles while the FSM is mid-frame → `full` asserts after 4 entries in the FIFO; extra writes are dropped; exactly the first accepted bytes are transmitted, in order.
4. **Reset mid-frame:** during DATA bit 3 with 2 bytes queued, assert `reset` for 1 cycle → `tx=1` on the reset edge; `count=0`, `busy=0`; a subsequent push of 0x0F transmits cleanly.
5. **Push at STOP boundary:** push a byte in the last STOP cycle of the current frame with the FIFO otherwise empty → the FSM goes to IDLE, then starts the new frame 1 clock later.
6. **Default parameters:** with defaults (DIV=868), send 0x41 → each bit lasts 868 clocks; an external receiver model at 115200 baud decodes 0x41.
